result_collector: RTL and testbench

//   Return-path counterpart of the batch stimulus driver. Captures each ALU result

---
 rtl/result_collector_if.sv | 12 +
 rtl/result_collector.sv | 111 +++++++++++
 tb/tb_result_collector.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// result_collector_if: result stream (valid/ready with last-beat marking) toward the host side
interface result_collector_if #(
    parameter int RES_WIDTH = 16
);
    logic                 m_tvalid;
    logic                 m_tready;
    logic [RES_WIDTH-1:0] m_tdata;
    logic                 m_tlast;

    modport master (output m_tvalid, m_tdata, m_tlast, input m_tready);
    modport slave  (input m_tvalid, m_tdata, m_tlast, output m_tready);
endinterface

// File: rtl/result_collector.sv
// result_collector: buffers a batch of bfm results and streams them back with last marking; optional checksum under COLLECT_CHECKSUM_EN
module result_collector #(
    parameter int NUM       = 100,
    parameter int RES_WIDTH = 16,
    parameter int CNT_W     = $clog2(NUM + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 done_i,
    input  logic [RES_WIDTH-1:0] res_i,
    input  logic                 flush_i,
    result_collector_if.master   m_if,
    output logic                 batch_done,
    output logic                 overflow,
    output logic [CNT_W-1:0]     count_o,
    output logic [RES_WIDTH-1:0] checksum_o
);
    localparam int AW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [RES_WIDTH-1:0] mem_q [NUM];
    logic [RES_WIDTH-1:0] tdata_q, first_d, next_d;
    logic                 tvalid_q, tlast_q, batch_done_q, overflow_q;
    logic                 cap, go, accept;

    // Capture/drain decisions; first_d bypasses the buffer when slot 0 is written on the drain-entry edge
    always_comb begin
        cap      = (state_q == COLLECT) && done_i;
        wr_idx_d = wr_idx_q + CNT_W'(cap);
        go       = (state_q == COLLECT) && ((wr_idx_d == CNT_W'(NUM)) || (flush_i && (wr_idx_d != '0)));
        accept   = tvalid_q && m_if.m_tready;
        rd_idx_d = rd_idx_q + CNT_W'(1);
        first_d  = (cap && (wr_idx_q == '0)) ? res_i : mem_q[0];
        next_d   = mem_q[rd_idx_d[AW-1:0]];
    end

    // Result buffer: written only while collecting, contents survive reset
    always_ff @(posedge clk_i) begin
        if (cap) mem_q[wr_idx_q[AW-1:0]] <= res_i;
    end

    // Collect/drain FSM with registered stream outputs
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= COLLECT;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            batch_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            batch_done_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    wr_idx_q <= wr_idx_d;
                    if (go) begin
                        state_q  <= DRAIN;
                        rd_idx_q <= '0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= first_d;
                        tlast_q  <= (wr_idx_d == CNT_W'(1));
                    end
                end
                DRAIN: begin
                    if (done_i) overflow_q <= 1'b1;
                    if (accept && tlast_q) begin
                        state_q      <= COLLECT;
                        wr_idx_q     <= '0;
                        rd_idx_q     <= '0;
                        tvalid_q     <= 1'b0;
                        tlast_q      <= 1'b0;
                        tdata_q      <= '0;
                        batch_done_q <= 1'b1;
                    end else if (accept) begin
                        rd_idx_q <= rd_idx_d;
                        tdata_q  <= next_d;
                        tlast_q  <= (rd_idx_d == wr_idx_q - CNT_W'(1));
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

`ifdef COLLECT_CHECKSUM_EN
    logic [RES_WIDTH-1:0] csum_q;

    // Running sum of captured results, cleared as the batch completes
    always_ff @(posedge clk_i) begin
        if (!reset_i) csum_q <= '0;
        else if (cap) csum_q <= csum_q + res_i;
        else if (accept && tlast_q && (state_q == DRAIN)) csum_q <= '0;
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

    assign m_if.m_tvalid = tvalid_q;
    assign m_if.m_tdata  = tdata_q;
    assign m_if.m_tlast  = tlast_q;
    assign batch_done    = batch_done_q;
    assign overflow      = overflow_q;
    assign count_o       = wr_idx_q;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed stimulus with a beat scoreboard checked by an independent monitor
module tb_result_collector;
    localparam int NUM = 4;
    localparam int W   = 16;
    localparam int CW  = $clog2(NUM + 1);
`ifdef COLLECT_CHECKSUM_EN
    localparam logic [W-1:0] CS_EXP = 16'h0001;
`else
    localparam logic [W-1:0] CS_EXP = 16'h0000;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          done_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [W-1:0]  res_i = '0;
    logic          batch_done, overflow;
    logic [CW-1:0] count_o;
    logic [W-1:0]  checksum_o;

    beat_t q[$];
    int    errs = 0;
    int    checks = 0;
    logic  bd_exp = 1'b0;

    result_collector_if #(.RES_WIDTH(W)) s_if ();

    result_collector #(.NUM(NUM), .RES_WIDTH(W)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .done_i    (done_i),
        .res_i     (res_i),
        .flush_i   (flush_i),
        .m_if      (s_if),
        .batch_done(batch_done),
        .overflow  (overflow),
        .count_o   (count_o),
        .checksum_o(checksum_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        q.push_back(b);
    endtask

    task automatic res(input logic [W-1:0] d);
        done_i = 1'b1;
        res_i  = d;
        step();
        done_i = 1'b0;
    endtask

    task automatic flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic drain_wait();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout_left", q.size(), 0);
        step();
        step();
    endtask

    // Monitor: pops expected beats on acceptance and checks the batch_done pulse one cycle after a last beat
    always @(negedge clk) begin
        beat_t e;
        if (bd_exp || batch_done) chk("batch_done", batch_done, bd_exp);
        bd_exp = 1'b0;
        if (s_if.m_tvalid && s_if.m_tready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", s_if.m_tdata, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("beat_data", s_if.m_tdata, e.d);
                chk("beat_last", s_if.m_tlast, e.l);
                if (s_if.m_tlast) bd_exp = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        s_if.m_tready = 1'b1;
        step();
        step();
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", s_if.m_tvalid, 0);
        chk("rst_tlast", s_if.m_tlast, 0);
        chk("rst_tdata", s_if.m_tdata, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", count_o, 0);
        chk("rst_checksum", checksum_o, 0);

        // Full batch, ready held high: four back-to-back beats
        push(16'h0001, 0); push(16'h0002, 0); push(16'h0003, 0); push(16'h0004, 1);
        res(16'h0001); res(16'h0002); res(16'h0003); res(16'h0004);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_tvalid", s_if.m_tvalid, 1);
            if (i == 0) chk("t1_count_full", count_o, 4);
        end
        @(negedge clk);
        chk("t1_count_after", count_o, 0);
        chk("t1_tvalid_after", s_if.m_tvalid, 0);
        drain_wait();

        // Backpressure: data holds while ready is low
        s_if.m_tready = 1'b0;
        push(16'h0021, 0); push(16'h0022, 0); push(16'h0023, 1);
        res(16'h0021); res(16'h0022); res(16'h0023);
        flush();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_tvalid", s_if.m_tvalid, 1);
            chk("t2_tdata_hold", s_if.m_tdata, 16'h0021);
        end
        chk("t2_count", count_o, 3);
        s_if.m_tready = 1'b1;
        drain_wait();

        // Flush with a same-cycle capture, then flush on an empty buffer
        push(16'h0010, 0); push(16'h0020, 0); push(16'h00AA, 1);
        res(16'h0010); res(16'h0020);
        done_i = 1'b1; res_i = 16'h00AA; flush_i = 1'b1;
        step();
        done_i = 1'b0; flush_i = 1'b0;
        drain_wait();
        flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_empty_flush_tvalid", s_if.m_tvalid, 0);
        end
        chk("t3_empty_flush_count", count_o, 0);

        // Result arriving during drain is dropped and sets sticky overflow
        s_if.m_tready = 1'b0;
        push(16'h0031, 0); push(16'h0032, 0); push(16'h0033, 0); push(16'h0034, 1);
        res(16'h0031); res(16'h0032); res(16'h0033); res(16'h0034);
        res(16'h0099);
        @(negedge clk);
        chk("t4_overflow", overflow, 1);
        chk("t4_count", count_o, 4);
        s_if.m_tready = 1'b1;
        drain_wait();
        chk("t4_overflow_sticky", overflow, 1);

        // Checksum wraps mod 2^16 and clears with batch completion
        s_if.m_tready = 1'b0;
        push(16'hFFFF, 0); push(16'h0002, 1);
        res(16'hFFFF); res(16'h0002);
        flush();
        @(negedge clk);
        chk("t6_checksum_drain", checksum_o, CS_EXP);
        chk("t6_overflow_sticky", overflow, 1);
        s_if.m_tready = 1'b1;
        drain_wait();
        @(negedge clk);
        chk("t6_checksum_after", checksum_o, 0);

        // Reset after two of four beats abandons the batch
        s_if.m_tready = 1'b0;
        push(16'h0051, 0); push(16'h0052, 0); push(16'h0053, 0); push(16'h0054, 1);
        res(16'h0051); res(16'h0052); res(16'h0053); res(16'h0054);
        s_if.m_tready = 1'b1;
        step();
        step();
        s_if.m_tready = 1'b0;
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        chk("t5_abandoned_beats", q.size(), 2);
        q.delete();
        @(negedge clk);
        chk("t5_tvalid", s_if.m_tvalid, 0);
        chk("t5_tlast", s_if.m_tlast, 0);
        chk("t5_tdata", s_if.m_tdata, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_count", count_o, 0);
        chk("t5_batch_done", batch_done, 0);
        s_if.m_tready = 1'b1;
        push(16'h0061, 0); push(16'h0062, 1);
        res(16'h0061); res(16'h0062);
        flush();
        drain_wait();

        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
